// File: rtl/generador_pkg.sv
// Shared types and helpers for the square-wave generator and its divider.
package generador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DIV   = 2'd2,
    RUN   = 2'd3
  } gen_state_t;

  localparam int unsigned DEF_CLK_HZ  = 50_000_000;
  localparam int unsigned MAX_FREQ_HZ = DEF_CLK_HZ / 2;

  // Width able to hold any count up to clk_hz inclusive.
  function automatic int unsigned calc_q_w(input int unsigned clk_hz);
    return $clog2(clk_hz + 1);
  endfunction

  function automatic int unsigned max_freq_hz(input int unsigned clk_hz);
    return clk_hz / 2;
  endfunction

endpackage

// File: rtl/generador_frecuencia_divisor_seq.sv
// Sequential restoring divider: W iterations, one quotient bit per cycle.
// The first iteration runs on the start edge; done pulses once the quotient is final.
module divisor_seq #(
  parameter int unsigned W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          done_q, done_d;

  logic [W:0]    rem_in, rem_sh, rem_n;
  logic [W-1:0]  quo_in, den_in, quo_n;
  logic          ge;

  // One restoring step; on start it works directly on the fresh operands.
  always_comb begin
    rem_in = start ? '0 : rem_q;
    quo_in = start ? dividend : quo_q;
    den_in = start ? divisor : den_q;
    rem_sh = (rem_in << 1) | {{W{1'b0}}, quo_in[W-1]};
    ge     = (rem_sh >= {1'b0, den_in});
    rem_n  = ge ? (rem_sh - {1'b0, den_in}) : rem_sh;
    quo_n  = {quo_in[W-2:0], ge};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    den_d  = den_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      rem_d = rem_n;
      quo_d = quo_n;
      den_d = divisor;
      cnt_d = CW'(W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = rem_n;
      quo_d = quo_n;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/generador_frecuencia.sv
// Programmable 50% square-wave source for frequency-meter self-test.
// Define GENERADOR_ROUND_EN to round the half-period count to nearest instead of floor.
//
// state | meaning
// IDLE  | nothing programmed (after reset or an illegal request)
// CHECK | range-check the latched frequency, kick the divider
// DIV   | divider computing the half-period count
// RUN   | generating; counter toggles signal every `half` cycles
module generador_frecuencia
  import generador_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned FREQ_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] freq_hz,
  input  logic              load,
  input  logic              enable,
  output logic              signal,
  output logic              busy,
  output logic              valid,
  output logic              err
);

  localparam int unsigned    Q_W      = calc_q_w(CLK_HZ);
  localparam logic [31:0]    MAX_HZ   = 32'(max_freq_hz(CLK_HZ));
  localparam logic [Q_W-1:0] HALF_CLK = Q_W'(CLK_HZ / 2);

  gen_state_t        state_q, state_d;
  logic [FREQ_W-1:0] f_q, f_d;
  logic [Q_W-1:0]    half_q, half_d;
  logic [Q_W-1:0]    cnt_q, cnt_d;
  logic              sig_q, sig_d;
  logic              err_q, err_d;

  logic              legal;
  logic              div_start, div_done;
  logic [Q_W-1:0]    div_divisor, div_dividend, div_quo;

  assign legal       = (f_q != '0) && (32'(f_q) <= MAX_HZ);
  // Safe truncation: only legal values (<= CLK_HZ/2) ever reach the divider.
  assign div_divisor = Q_W'(f_q);
`ifdef GENERADOR_ROUND_EN
  assign div_dividend = HALF_CLK + (div_divisor >> 1);
`else
  assign div_dividend = HALF_CLK;
`endif

  divisor_seq #(.W(Q_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  always_comb begin
    state_d   = state_q;
    f_d       = f_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    sig_d     = sig_q;
    err_d     = err_q;
    div_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          f_d     = freq_hz;
          state_d = CHECK;
        end
      end
      CHECK: begin
        sig_d = 1'b0;
        if (!legal) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          err_d     = 1'b0;
          div_start = 1'b1;
          state_d   = DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          half_d  = div_quo;
          cnt_d   = '0;
          sig_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (load) begin
          f_d     = freq_hz;
          cnt_d   = '0;
          sig_d   = 1'b0;
          state_d = CHECK;
        end else if (!enable) begin
          cnt_d = '0;
          sig_d = 1'b0;
        end else if (cnt_q == half_q - Q_W'(1)) begin
          cnt_d = '0;
          sig_d = ~sig_q;
        end else begin
          cnt_d = cnt_q + Q_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      f_q     <= '0;
      half_q  <= '0;
      cnt_q   <= '0;
      sig_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
    end
  end

  assign signal = sig_q;
  assign busy   = (state_q == CHECK) || (state_q == DIV);
  assign valid  = (state_q == RUN);
  assign err    = err_q;

endmodule

// File: tb/tb_generador_frecuencia.sv
// Directed bench for generador_frecuencia at CLK_HZ=1000 (Q_W=10).
module tb_generador_frecuencia;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned FREQ_W = 20;
  localparam int BUSY_LEGAL = 11;
`ifdef GENERADOR_ROUND_EN
  localparam int HALF3 = 167;
`else
  localparam int HALF3 = 166;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [FREQ_W-1:0] freq_hz;
  logic              load;
  logic              enable;
  logic              signal, busy, valid, err;

  int n_total = 0;
  int n_pass  = 0;

  generador_frecuencia #(.CLK_HZ(CLK_HZ), .FREQ_W(FREQ_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .freq_hz (freq_hz),
    .load    (load),
    .enable  (enable),
    .signal  (signal),
    .busy    (busy),
    .valid   (valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int freq;
    int exp_err;
    int exp_half;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a load, verify the load edge, busy length and flags; measure one period.
  task automatic do_load(input int f, input int exp_err, input int exp_half);
    int nb;
    int lo;
    int hi;
    freq_hz = FREQ_W'(f);
    load    = 1'b1;
    step();
    load    = 1'b0;
    check($sformatf("f=%0d load_edge_valid", f), int'(valid), 0);
    check($sformatf("f=%0d load_edge_signal", f), int'(signal), 0);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      step();
    end
    check($sformatf("f=%0d busy_cycles", f), nb, exp_err ? 1 : BUSY_LEGAL);
    check($sformatf("f=%0d err", f), int'(err), exp_err);
    check($sformatf("f=%0d valid", f), int'(valid), exp_err ? 0 : 1);
    if (exp_err != 0) begin
      check($sformatf("f=%0d signal_idle", f), int'(signal), 0);
    end else begin
      lo = 0;
      while (!signal && lo < 2000) begin
        lo++;
        step();
      end
      hi = 0;
      while (signal && hi < 2000) begin
        hi++;
        step();
      end
      check($sformatf("f=%0d low_time", f), lo, exp_half);
      check($sformatf("f=%0d high_time", f), hi, exp_half);
    end
  endtask

  initial begin
    vec_t vecs[7];
    int   n;
    int   gap_bad;
    int   gap_invalid;

    vecs[0] = '{freq: 1,      exp_err: 0, exp_half: 500};
    vecs[1] = '{freq: 500,    exp_err: 0, exp_half: 1};
    vecs[2] = '{freq: 0,      exp_err: 1, exp_half: 0};
    vecs[3] = '{freq: 501,    exp_err: 1, exp_half: 0};
    vecs[4] = '{freq: 250,    exp_err: 0, exp_half: 2};
    vecs[5] = '{freq: 3,      exp_err: 0, exp_half: HALF3};
    vecs[6] = '{freq: 999999, exp_err: 1, exp_half: 0};

    rst     = 1'b1;
    load    = 1'b0;
    enable  = 1'b1;
    freq_hz = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_signal", int'(signal), 0);
    check("reset_busy",   int'(busy),   0);
    check("reset_valid",  int'(valid),  0);
    check("reset_err",    int'(err),    0);

    for (int i = 0; i < 7; i++)
      do_load(vecs[i].freq, vecs[i].exp_err, vecs[i].exp_half);

    // Enable gap with f=10 (half=50 floor or rounded).
    do_load(10, 0, 50);
    enable = 1'b0;
    gap_bad     = 0;
    gap_invalid = 0;
    for (int k = 0; k < 37; k++) begin
      step();
      if (signal) gap_bad++;
      if (!valid) gap_invalid++;
    end
    check("gap_signal_high_samples", gap_bad, 0);
    check("gap_valid_low_samples", gap_invalid, 0);
    enable = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!signal && n < 200);
    check("enable_first_toggle", n, 50);

    // Reset on the 5th busy cycle after load f=7, with a simultaneous load.
    freq_hz = FREQ_W'(7);
    load    = 1'b1;
    step();
    load    = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("mid_div_busy", int'(busy), 1);
    rst     = 1'b1;
    load    = 1'b1;
    freq_hz = FREQ_W'(20);
    step();
    rst  = 1'b0;
    load = 1'b0;
    check("rst_mid_signal", int'(signal), 0);
    check("rst_mid_busy",   int'(busy),   0);
    check("rst_mid_valid",  int'(valid),  0);
    check("rst_mid_err",    int'(err),    0);
    step();
    step();
    check("rst_load_ignored_busy",  int'(busy),  0);
    check("rst_load_ignored_valid", int'(valid), 0);

    // Reprogram during RUN.
    do_load(10, 0, 50);
    do_load(20, 0, 25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/generador_frecuencia.md
Name: generador_frecuencia

Overview:
- Programmable square-wave source that drives the frequency-meter input pin (GPIO) for board self-test: the transmit end of the frequency-measurement path.
- Takes a requested frequency in Hz and derives a half-period count with a sequential divider.
- Toggles `signal` on that count.
- Range 1 Hz .. CLK_HZ/2 (25 MHz at 50 MHz clock).

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz.
- FREQ_W, 20, width of `freq_hz` (covers 999_999, the 6-digit display range).
- Derived localparam Q_W = $clog2(CLK_HZ+1): quotient/counter width (26 at default).

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  synchronous reset, active-high.
- freq_hz  in  FREQ_W  requested frequency, unsigned binary Hz; sampled only on `load`.
- load  in  1  one-cycle strobe: latch `freq_hz` and recompute.
- enable  in  1  output gate; low freezes generation.
- signal  out  1  generated square wave, 50% duty.
- busy  out  1  divider running; `load` ignored while high.
- valid  out  1  a legal frequency is programmed and generation is active.
- err  out  1  last `load` requested 0 Hz or more than CLK_HZ/2 Hz.

Behaviour:
- Reset: signal=0, busy=0, valid=0, err=0, state IDLE, counter=0, half=0.
- FSM states: IDLE, CHECK, DIV, RUN.
- IDLE:
  - `load` latches f=freq_hz and goes to CHECK.
- CHECK (1 cycle, busy=1):
  - If f==0 or f>CLK_HZ/2: err=1, valid=0, signal=0, go to IDLE.
  - Otherwise: err=0, start the divider, go to DIV.
- DIV (busy=1):
  - Restoring divider, exactly Q_W iterations, one quotient bit per cycle.
  - Dividend = CLK_HZ/2, divisor = f, half = floor(dividend/f).
  - After the last iteration, go to RUN with counter=0 and signal=0.
- Load-to-RUN latency:
  - `load` is sampled at edge N; busy is high from N+1 through N+Q_W+1.
  - At edge N+Q_W+2: busy=0 and valid=1.
- RUN (valid=1):
  - enable=1: counter increments each cycle. When counter==half-1, counter wraps to 0 and signal toggles.
  - Output period is 2*half clocks.
  - half==1 gives a toggle every cycle (CLK_HZ/2 output).
  - enable=0: counter held at 0, signal forced 0, valid stays 1. Generation restarts from phase 0 when enable rises.
- `load` during RUN:
  - signal=0 and valid=0 on the next edge, then CHECK.
  - The old setting is discarded even if the new value is illegal.
- `load` during CHECK or DIV: ignored.
- `rst` asserted in any state, including mid-DIV: immediate return to reset values on that edge. No partial quotient is retained.
- `load` and `rst` in the same cycle: `rst` wins.
- Arithmetic:
  - f is zero-extended to Q_W bits.
  - The divider remainder register is Q_W+1 bits.
  - The quotient is always ≥1 for legal f.

Optional Feature:
- Macro: GENERADOR_ROUND_EN.
- Defined: dividend = CLK_HZ/2 + floor(f/2), so `half` is the round-to-nearest value. Latency is unchanged; Q_W still suffices.
- Undefined: dividend = CLK_HZ/2 (floor). Output frequency is always ≥ the requested frequency.

Decomposition:
- Package `generador_pkg`:
  - FSM state enum (IDLE, CHECK, DIV, RUN).
  - Function computing Q_W from CLK_HZ.
  - Localparam for the maximum legal frequency (CLK_HZ/2).
- Sub-module `divisor_seq`:
  - Parameterised width, start/done handshake, restoring algorithm, synchronous reset.
  - Ports: clk, rst, start, dividend, divisor, quotient, done.
  - Reusable by the frequency meter for the Hz computation.

Test Plan:
- CLK_HZ=1000 (Q_W=10), load f=1:
  - busy high exactly 11 cycles.
  - Then valid=1, half=500, signal period 1000 clocks, 500 high / 500 low.
- load f=500:
  - half=1, signal toggles every cycle once valid.
- load f=0, then f=501:
  - Each gives err=1, valid=0, signal=0, busy high 1 cycle only.
  - A following load f=250 clears err and yields period 4.
- load f=3:
  - ROUND_EN undefined: half=166, period 332.
  - ROUND_EN defined: half=167, period 334.
- In RUN with f=10: drop enable for 37 cycles, then raise it.
  - signal=0 during the gap.
  - First toggle occurs 50 cycles after enable rises.
- Reset mid-operation:
  - Assert rst on the 5th busy cycle after load f=7: all outputs 0 next edge. A pulse on `load` in the same cycle as rst has no effect.
  - Load f=20 during RUN: signal=0 and valid=0 next edge, new period 50 clocks after 11 busy cycles.
